// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard for the 5-stage RV32 pipe: load-in-EX and
// outstanding mul/div tracking, stall/bubble/flush/freeze control, stall watchdog.
module hazard_scoreboard #(
    parameter int STALL_TO = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_RegWEn,
    input  logic             id_is_load,
    input  logic             id_is_md,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             md_done,
    input  logic [4:0]       md_rd_addr,
    output logic             freeze,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             md_busy,
    output logic             hazard_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WD_W    = 10;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TO - 1);

    function automatic logic src_hit(input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic use1,
                                     input logic [4:0] rs2, input logic use2);
        return (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    logic             ex_load_vld_q, ex_load_vld_d;
    logic [4:0]       ex_load_rd_q, ex_load_rd_d;
    logic             md_pend_q, md_pend_d;
    logic [4:0]       md_pend_rd_q, md_pend_rd_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             hazard_err_q, hazard_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use_s, md_raw_s, md_waw_s, md_struct_s, hz_s;
    logic frz_req_s, advance_s, hz_stall_s, md_done_hit_s;

    // Hazard detection against the load in EX and the outstanding mul/div
    always_comb begin
        load_use_s    = ex_load_vld_q &&
                        src_hit(ex_load_rd_q, id_rs1_addr, id_rs1_use, id_rs2_addr, id_rs2_use);
        md_raw_s      = md_pend_q &&
                        src_hit(md_pend_rd_q, id_rs1_addr, id_rs1_use, id_rs2_addr, id_rs2_use);
        md_waw_s      = md_pend_q && id_RegWEn && (id_rd_addr == md_pend_rd_q);
        md_struct_s   = md_pend_q && id_is_md;
        hz_s          = load_use_s || md_raw_s || md_waw_s || md_struct_s;
        frz_req_s     = imem_stall || dmem_stall;
        advance_s     = !frz_req_s && !ex_br_taken && !hz_s;
        hz_stall_s    = !frz_req_s && !ex_br_taken && hz_s;
        md_done_hit_s = md_done && md_pend_q && (md_rd_addr == md_pend_rd_q);
    end

    // Pipeline control outputs; forced low while reset is asserted
    always_comb begin
        freeze       = rstn && frz_req_s;
        flush_if_id  = rstn && !frz_req_s && ex_br_taken;
        flush_id_ex  = rstn && !frz_req_s && ex_br_taken;
        stall_if_id  = rstn && hz_stall_s;
        bubble_id_ex = rstn && hz_stall_s;
        md_busy      = md_pend_q;
        hazard_err   = hazard_err_q;
        stall_cnt    = stall_cnt_q;
    end

    // Next state of the EX-stage load tracker
    always_comb begin
        ex_load_vld_d = ex_load_vld_q;
        ex_load_rd_d  = ex_load_rd_q;
        if (frz_req_s) begin
            ex_load_vld_d = ex_load_vld_q;
        end else if (advance_s) begin
            ex_load_vld_d = id_is_load && id_RegWEn;
            ex_load_rd_d  = id_rd_addr;
        end else begin
            ex_load_vld_d = 1'b0;
        end
    end

    // Next state of the mul/div tracker; issue wins over retire, retire ignores freeze
    always_comb begin
        md_pend_d    = md_pend_q;
        md_pend_rd_d = md_pend_rd_q;
        if (advance_s && id_is_md && id_RegWEn && (id_rd_addr != 5'd0)) begin
            md_pend_d    = 1'b1;
            md_pend_rd_d = id_rd_addr;
        end else if (md_done_hit_s) begin
            md_pend_d = 1'b0;
        end else begin
            md_pend_d = md_pend_q;
        end
    end

    // Watchdog (saturating run length of consecutive stalls) and stall counter
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        hazard_err_d = hazard_err_q || (hz_stall_s && (wd_cnt_q >= WD_LAST));
        stall_cnt_d  = stall_cnt_q;
        if (frz_req_s) begin
            wd_cnt_d = wd_cnt_q;
        end else if (hz_stall_s) begin
            wd_cnt_d    = (wd_cnt_q >= WD_LAST) ? wd_cnt_q : wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wd_cnt_d = {WD_W{1'b0}};
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_load_vld_q <= 1'b0;
            ex_load_rd_q  <= 5'd0;
            md_pend_q     <= 1'b0;
            md_pend_rd_q  <= 5'd0;
            wd_cnt_q      <= {WD_W{1'b0}};
            hazard_err_q  <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            ex_load_vld_q <= ex_load_vld_d;
            ex_load_rd_q  <= ex_load_rd_d;
            md_pend_q     <= md_pend_d;
            md_pend_rd_q  <= md_pend_rd_d;
            wd_cnt_q      <= wd_cnt_d;
            hazard_err_q  <= hazard_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side counterpart of the EX-stage operand forwarding unit in the 5-stage RV32 core.
- Forwarding serves consumers in EX from the ME/WB write sources. This block tracks writers that forwarding cannot yet serve: a load sitting in EX, and an in-flight iterative mul/div result.
- For those cases it generates stall, bubble and flush controls for the IF/ID/EX pipeline registers.
- It also freezes the whole pipe on cache/memory wait and raises a watchdog error on a runaway stall.

Parameters:
- STALL_TO, 64, consecutive hazard-stall cycles before hazard_err is set (range 2..1023).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- id_rs1_addr  in  5  ID source register 1.
- id_rs2_addr  in  5  ID source register 2.
- id_rs1_use  in  1  ID instruction reads rs1.
- id_rs2_use  in  1  ID instruction reads rs2.
- id_rd_addr  in  5  ID destination.
- id_RegWEn  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_md  in  1  ID instruction is a mul/div (iterative unit).
- ex_br_taken  in  1  EX resolved taken branch/jump.
- imem_stall  in  1  instruction-side wait.
- dmem_stall  in  1  data-side wait.
- md_done  in  1  mul/div unit writes its result this cycle.
- md_rd_addr  in  5  destination of the md_done result.
- freeze  out  1  hold every pipeline register.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- md_busy  out  1  mul/div result outstanding.
- hazard_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  hazard-stall cycles since reset.

Behaviour:
- State:
  - ex_load_vld / ex_load_rd: load currently in EX.
  - md_pend / md_pend_rd: one outstanding mul/div (md_busy = md_pend).
  - wd_cnt: watchdog count.
  - hazard_err, stall_cnt.
- Reset (rstn low, async): all state 0; every output 0.
- All control outputs are combinational from state plus current inputs. State updates on posedge clk.
- Hazard terms:
  - Register x0 never hazards.
  - load_use = ex_load_vld and ex_load_rd != 0 and ((id_rs1_use and id_rs1_addr == ex_load_rd) or (id_rs2_use and id_rs2_addr == ex_load_rd)).
  - md_raw = md_pend and a used source equals md_pend_rd.
  - md_waw = md_pend and id_RegWEn and id_rd_addr == md_pend_rd.
  - md_struct = md_pend and id_is_md.
  - hz = load_use or md_raw or md_waw or md_struct.
- Output priority: freeze > flush > stall.
  - freeze = imem_stall or dmem_stall. While frozen, all other pipeline outputs are 0 and ex_load_*, wd_cnt and stall_cnt hold.
  - Not frozen, ex_br_taken = 1: flush_if_id = flush_id_ex = 1; stall_if_id = bubble_id_ex = 0. The ID instruction is squashed and makes no scoreboard update.
  - Not frozen, no flush, hz = 1: stall_if_id = bubble_id_ex = 1.
- Advance: "ID advances" = not freeze, not ex_br_taken, not hz.
- ex_load update, every non-frozen cycle:
  - If ID advances: ex_load_vld <= id_is_load and id_RegWEn; ex_load_rd <= id_rd_addr.
  - Otherwise (bubble or flush): ex_load_vld <= 0.
  - Load-use therefore costs exactly 1 stall cycle. The load then sits in ME and is served by forwarding.
- md_pend:
  - Set on an ID advance with id_is_md and id_RegWEn and id_rd_addr != 0; md_pend_rd <= id_rd_addr.
  - Cleared by md_done when md_done and md_rd_addr == md_pend_rd. md_done is honoured even while frozen; the mul/div unit runs independently.
  - If set and clear occur in the same cycle, set wins. This happens only when md_done retires the old op while a new md issues; md_struct forbids that case, so a new issue never coincides with a pending op.
  - Clearing takes effect at the edge. A dependent in ID during the md_done cycle stalls that cycle and advances the next one.
  - md_done with no pending op or a mismatched rd: ignored.
- Watchdog and counter:
  - wd_cnt increments on each non-frozen cycle with hz and no flush. It is reset to 0 on any ID advance or flush.
  - When wd_cnt reaches STALL_TO - 1 while still stalling, hazard_err <= 1, sticky until reset.
  - stall_cnt increments on each hazard-stall cycle and wraps modulo 2^CNT_W.
- Reset asserted mid-operation drops pending state immediately; outputs go low within the same cycle, asynchronously.

Test Plan:
- Load-use: issue lw x5 (ID advance), next cycle ID add x6,x5,x1 -> stall_if_id = bubble_id_ex = 1 for exactly 1 cycle, then advance; stall_cnt = 1.
- Zero/unused reg: lw x0 followed by add using x0; lw x7 followed by lui x7 (rs unused) -> no stall.
- Mul/div: issue div x9; ID add x3,x9,x2 -> stall until md_done with md_rd_addr = 9 pulses at cycle 12; add advances at cycle 13; md_busy falls at cycle 13. Second mul issued while pending -> stalled (md_struct); mul to x9 while pending -> stalled (md_waw).
- Priority: load_use and ex_br_taken in the same cycle -> flush_if_id = flush_id_ex = 1, no stall, ex_load_vld = 0 next. Add dmem_stall = 1 -> only freeze = 1; state holds; md_done during freeze still clears md_pend.
- Watchdog: STALL_TO = 4, md_pend with md_done withheld, dependent in ID -> hazard_err rises after the 4th stall cycle and stays 1 after md_done.
- Async reset: assert rstn = 0 mid mul/div stall, off-edge -> all outputs 0 immediately; after release, the dependent advances without stall.
